// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared FSM state encoding and mode constants for mem_copy_engine.
// Contents: state_t (IDLE, RD, WR, FILL, FIN), MODE_COPY / MODE_FILL.
// Imported by rtl/mem_copy_engine.sv.
package mem_copy_pkg;

  // Explicit encoding keeps the state register stable across tool versions.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // States in which the engine owns the memory port.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_RD) || (s == ST_WR) || (s == ST_FILL);
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / block fill initiator on the word-addressed data memory port.
// Latency: COPY 2 cycles/word (done 2*len+1 cycles after start), FILL 1 cycle/word (done len+1), len==0 done after 1.
// Backpressure: none; memory is single-cycle. abort cancels in RD/WR/FILL, start is ignored unless IDLE.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_abort      start request (sampled in IDLE), cancel current transfer
//   i_mode                0 = COPY, 1 = FILL
//   i_src_addr, i_dst_addr, i_len, i_fill_val   transfer operands, latched on accepted start
//   o_mem_req, o_mem_addr, o_mem_we, o_mem_wd, i_mem_rd   memory port (combinational read)
//   o_busy, o_done        transfer in progress, one-cycle completion pulse
//   o_checksum            sum of written words; present only when MEM_COPY_CHECKSUM_EN is defined
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [31:0]       i_fill_val,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wd,
  input  logic [31:0]       i_mem_rd,
  output logic              o_busy,
  output logic              o_done
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       o_checksum
`endif
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_cnt;
  logic [31:0]       r_buf;
  logic [31:0]       r_fill_val;

  logic w_busy;
  logic w_last;
  logic w_accept;
  logic w_wr_commit;

  assign w_busy   = is_busy_state(r_state);
  assign w_last   = (r_cnt == LEN_W'(1));
  assign w_accept = (r_state == ST_IDLE) && i_start;
  // A write only lands in memory when it is not cancelled in the same cycle.
  assign w_wr_commit = ((r_state == ST_WR) || (r_state == ST_FILL)) && !i_abort;

  assign o_busy    = w_busy;
  assign o_mem_req = w_busy;
  assign o_done    = (r_state == ST_FIN);

  always_comb begin
    o_mem_addr = '0;
    o_mem_we   = 1'b0;
    o_mem_wd   = '0;
    case (r_state)
      ST_RD: begin
        o_mem_addr = r_src_ptr;
      end
      ST_WR: begin
        o_mem_addr = r_dst_ptr;
        o_mem_we   = !i_abort;
        o_mem_wd   = r_buf;
      end
      ST_FILL: begin
        o_mem_addr = r_dst_ptr;
        o_mem_we   = !i_abort;
        o_mem_wd   = r_fill_val;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_src_ptr  <= '0;
      r_dst_ptr  <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_fill_val <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_src_ptr  <= i_src_addr;
            r_dst_ptr  <= i_dst_addr;
            r_cnt      <= i_len;
            r_fill_val <= i_fill_val;
            if (i_len == '0)
              r_state <= ST_FIN;
            else if (i_mode == MODE_FILL)
              r_state <= ST_FILL;
            else
              r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_buf     <= i_mem_rd;
            r_src_ptr <= r_src_ptr + ADDR_W'(1);
            r_state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
            r_cnt     <= r_cnt - LEN_W'(1);
            r_state   <= w_last ? ST_FIN : ST_RD;
          end
        end
        ST_FILL: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
            r_cnt     <= r_cnt - LEN_W'(1);
            if (w_last)
              r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Holds after FIN or abort; only a newly accepted start clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= '0;
    else if (w_wr_commit)
      r_checksum <= r_checksum + o_mem_wd;
  end

  assign o_checksum = r_checksum;
`else
  // Keep the commit qualifier referenced so both builds share one definition.
  logic w_unused;
  assign w_unused = w_accept ^ w_wr_commit;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: self-checking bench for mem_copy_engine with a 256-word behavioural memory.
// Reference model applies the transfer word by word on an array copy of memory.
// Build with MEM_COPY_CHECKSUM_EN defined to also exercise the checksum output.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] fill_val;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic        done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(32), .LEN_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_mode     (mode),
    .i_src_addr (src_addr),
    .i_dst_addr (dst_addr),
    .i_len      (len),
    .i_fill_val (fill_val),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_wd   (mem_wd),
    .i_mem_rd   (mem_rd),
    .o_busy     (busy),
    .o_done     (done)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .o_checksum (checksum)
`endif
  );

  // Data memory responder: combinational read, write on clock edge, aliased mod 256.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_dat;

  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (init_we)
      mem[init_addr] <= init_dat;
    else if (mem_we)
      mem[mem_addr[7:0]] <= mem_wd;
  end

  int nchk = 0;
  int nerr = 0;

  int obs_done_cyc;
  int obs_done_cnt;
  int obs_busy;
  int obs_we;
  logic [31:0] exp_sum;

  typedef struct {
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [31:0] fill;
    int          poke_cyc;    // cycle index for an injected event, 0 = none
    int          poke_kind;   // 1 = extra start pulse, 2 = abort
    int          model_words; // words that actually reach memory
    int          exp_done;    // cycle of done after start edge, -1 = never
    int          exp_busy;
    int          exp_we;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic poke_mem(input int a, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = a[7:0];
    init_dat  = d;
    ref_mem[a[7:0]] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // Higher-level model: ascending word-by-word transfer on the reference array.
  task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input int n, input logic [31:0] f);
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa;
      logic [31:0] da;
      logic [31:0] w;
      sa = s + 32'(i);
      da = d + 32'(i);
      w  = m ? f : ref_mem[sa[7:0]];
      ref_mem[da[7:0]] = w;
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic check_mem(input string name);
    int nbad;
    int first;
    nbad  = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    if (nbad != 0)
      $display("memory differs first at word %0d: 0x%0h vs model 0x%0h", first, mem[first], ref_mem[first]);
    check(name, nbad, 0);
  endtask

  // Issues one start at #1 after an edge, then observes `window` cycles.
  task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input int l, input logic [31:0] f,
                          input int poke_cyc, input int poke_kind, input int window);
    @(posedge clk); #1;
    mode = m; src_addr = s; dst_addr = d; len = 16'(l); fill_val = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs_done_cyc = -1; obs_done_cnt = 0; obs_busy = 0; obs_we = 0;
    for (int c = 1; c <= window; c++) begin
      if (c == poke_cyc) begin
        if (poke_kind == 1) begin
          start = 1'b1; dst_addr = 32'd200; len = 16'd1;
        end else if (poke_kind == 2) begin
          abort = 1'b1;
        end
      end
      @(negedge clk);
      if (done) begin
        if (obs_done_cyc < 0) obs_done_cyc = c;
        obs_done_cnt++;
      end
      if (busy)   obs_busy++;
      if (mem_we) obs_we++;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    run_xfer(v.mode, v.src, v.dst, v.len, v.fill, v.poke_cyc, v.poke_kind,
             (v.exp_done < 0) ? 12 : v.exp_done + 4);
    model(v.mode, v.src, v.dst, v.model_words, v.fill);
    check({tag, " done_cycle"}, obs_done_cyc, v.exp_done);
    check({tag, " done_pulses"}, obs_done_cnt, (v.exp_done < 0) ? 0 : 1);
    check({tag, " busy_cycles"}, obs_busy, v.exp_busy);
    check({tag, " write_pulses"}, obs_we, v.exp_we);
    check_mem({tag, " memory"});
`ifdef MEM_COPY_CHECKSUM_EN
    check({tag, " checksum"}, checksum, exp_sum);
`endif
  endtask

  initial begin
    vec_t rv;
    //          mode       src            dst            len fill           poke kind words done busy we
    vecs[0] = '{1'b0, 32'd0,         32'd8,          4, 32'h0,          0, 0, 4,  9, 8, 4};
    vecs[1] = '{1'b1, 32'd0,         32'd20,         3, 32'hDEADBEEF,   0, 0, 3,  4, 3, 3};
    vecs[2] = '{1'b0, 32'd5,         32'd30,         0, 32'h0,          0, 0, 0,  1, 0, 0};
    vecs[3] = '{1'b0, 32'd0,         32'd70,         4, 32'h0,          4, 2, 1, -1, 4, 1};
    vecs[4] = '{1'b0, 32'd0,         32'd80,         2, 32'h0,          0, 0, 2,  5, 4, 2};
    vecs[5] = '{1'b1, 32'd0,         32'd60,         5, 32'h5A5A0001,   2, 1, 5,  6, 5, 5};
    vecs[6] = '{1'b0, 32'd40,        32'd41,         3, 32'h0,          0, 0, 3,  7, 6, 3};
    vecs[7] = '{1'b1, 32'd0,         32'hFFFFFFFE,   4, 32'h12345678,   0, 0, 4,  5, 4, 4};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,  32'd200,        3, 32'h0,          0, 0, 3,  7, 6, 3};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    init_we = 1'b0; init_addr = '0; init_dat = '0;

    @(negedge clk);
    check("reset mem_req", mem_req, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wd", mem_wd, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("reset checksum", checksum, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 256; i++) poke_mem(i, $urandom);
    poke_mem(0, 32'd11);
    poke_mem(1, 32'd22);
    poke_mem(2, 32'd33);
    poke_mem(3, 32'd44);

    for (int i = 0; i < 9; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a COPY: one word written, outputs drop at once, no done.
    @(posedge clk); #1;
    mode = 1'b0; src_addr = 32'd100; dst_addr = 32'd150; len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset mem_req", mem_req, 0);
    check("midreset busy", busy, 0);
    check("midreset mem_we", mem_we, 0);
    check("midreset mem_addr", mem_addr, 0);
    check("midreset mem_wd", mem_wd, 0);
    model(1'b0, 32'd100, 32'd150, 1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs_done_cnt = 0; obs_busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) obs_done_cnt++;
      if (busy) obs_busy++;
    end
    check("midreset done_pulses", obs_done_cnt, 0);
    check("midreset busy_cycles", obs_busy, 0);
    check_mem("midreset memory");
`ifdef MEM_COPY_CHECKSUM_EN
    check("midreset checksum", checksum, 0);
`endif

`ifdef MEM_COPY_CHECKSUM_EN
    @(posedge clk); #1;
    poke_mem(100, 32'd1);
    poke_mem(101, 32'd2);
    poke_mem(102, 32'd3);
    poke_mem(103, 32'hFFFFFFFF);
    run_xfer(1'b0, 32'd100, 32'd110, 4, 32'h0, 0, 0, 13);
    model(1'b0, 32'd100, 32'd110, 4, 32'h0);
    check("checksum wrap sum", checksum, 32'h00000005);
    check_mem("checksum memory");
`endif

    // Randomized transfers against the model.
    for (int k = 0; k < 20; k++) begin
      rv.mode        = 1'($urandom_range(0, 1));
      rv.src         = $urandom;
      rv.dst         = $urandom;
      rv.len         = $urandom_range(0, 10);
      rv.fill        = $urandom;
      rv.poke_cyc    = 0;
      rv.poke_kind   = 0;
      rv.model_words = rv.len;
      rv.exp_done    = (rv.len == 0) ? 1 : (rv.mode ? rv.len + 1 : 2 * rv.len + 1);
      rv.exp_busy    = rv.mode ? rv.len : 2 * rv.len;
      rv.exp_we      = rv.len;
      run_and_check($sformatf("rand%0d", k), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
